// File: rtl/gb_mem_pkg.sv
// Shared memory-map constants and DMA state encoding for the OAM DMA path.
package gb_mem_pkg;

    localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;
    localparam logic [15:0] OAM_BASE      = 16'hFE00;
    localparam int unsigned OAM_LEN       = 160;
    localparam logic [7:0]  BLOCKED_RDATA = 8'hFF;

    typedef enum logic [1:0] {IDLE, RD, WR} dma_state_e;

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA sequencer: alternates read-from-page / write-to-OAM for each byte.
module oam_dma_engine
    import gb_mem_pkg::*;
#(
    parameter int unsigned OAM_LEN = gb_mem_pkg::OAM_LEN,
    parameter logic [15:0] DMA_REG = DMA_REG_ADDR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  dma_src,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_wdata,
    output logic        dma_we,
    output logic        dma_re
);

    dma_state_e state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] dma_src_q, dma_src_d;
    logic       start;

    assign start = cpu_we && (cpu_addr == DMA_REG);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= 8'h00;
            byte_q    <= 8'h00;
            dma_src_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            byte_q    <= byte_d;
            dma_src_q <= dma_src_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        byte_d    = byte_q;
        dma_src_d = dma_src_q;
        dma_addr  = 16'h0000;
        dma_wdata = 8'h00;
        dma_we    = 1'b0;
        dma_re    = 1'b0;

        unique case (state_q)
            RD: begin
                dma_addr = {dma_src_q, idx_q};
                dma_re   = 1'b1;
                byte_d   = mem_rdata;
                state_d  = WR;
            end
            WR: begin
                dma_addr  = OAM_BASE + {8'h00, idx_q};
                dma_wdata = byte_q;
                dma_we    = 1'b1;
                if (idx_q == 8'(OAM_LEN - 1)) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = RD;
                end
            end
            default: ;
        endcase

        // A register write (re)starts the copy from byte 0, discarding any pending byte.
        if (start) begin
            dma_src_d = cpu_wdata;
            idx_d     = 8'h00;
            state_d   = RD;
        end
    end

    assign dma_src    = dma_src_q;
    assign dma_active = (state_q != IDLE);

endmodule

// File: rtl/oam_dma_arbiter.sv
// Shares the single memory port between CPU pass-through and the OAM DMA engine.
module oam_dma_arbiter
    import gb_mem_pkg::*;
#(
    parameter int unsigned OAM_LEN = gb_mem_pkg::OAM_LEN,
    parameter logic [15:0] DMA_REG = DMA_REG_ADDR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_oe,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active
);

    logic [7:0]  dma_src;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_we;
    logic        dma_re;
    logic        reg_hit;

    assign reg_hit = (cpu_addr == DMA_REG);

    oam_dma_engine #(
        .OAM_LEN (OAM_LEN),
        .DMA_REG (DMA_REG)
    ) u_engine (
        .clock      (clock),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .mem_rdata  (mem_rdata),
        .dma_src    (dma_src),
        .dma_active (dma_active),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_we     (dma_we),
        .dma_re     (dma_re)
    );

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_oe    = 1'b0;
        cpu_rdata = mem_rdata;

        if (dma_active) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we;
            mem_re    = dma_re;
            mem_oe    = dma_we;
        end else if (!reg_hit) begin
            mem_we = cpu_we;
            mem_re = cpu_re;
            mem_oe = cpu_we;
        end

        // The DMA register is local; other CPU reads are blocked while a copy runs.
        if (reg_hit) begin
            cpu_rdata = dma_src;
        end else if (dma_active) begin
            cpu_rdata = BLOCKED_RDATA;
        end
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench: byte-wide memory model behind the arbiter, hand-computed expectations.
module tb_oam_dma_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic [7:0]  cpu_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_oe;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        dma_active;

    logic [7:0] mem [0:65535];
    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_addr];

    oam_dma_arbiter u_dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .cpu_re     (cpu_re),
        .cpu_rdata  (cpu_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_oe     (mem_oe),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .dma_active (dma_active)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory write happens at the edge with the values settled in the ending cycle.
    task automatic tick();
        if (mem_we && mem_oe) mem[mem_addr] = mem_wdata;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_bus();
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        cpu_we    = 1'b0;
        cpu_re    = 1'b0;
    endtask

    task automatic start_dma(input logic [7:0] page);
        cpu_addr  = 16'hFF46;
        cpu_wdata = page;
        cpu_we    = 1'b1;
        tick();
        idle_bus();
    endtask

    task automatic check_oam(input string tag, input int lo, input int hi, input logic [7:0] key);
        int errs = 0;
        for (int i = lo; i <= hi; i++) begin
            if (mem[16'hFE00 + i] !== (8'(i) ^ key)) errs++;
        end
        check_eq(tag, errs, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int we_cnt;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 160; i++) begin
            mem[16'hC000 + i] = 8'(i) ^ 8'h5A;
            mem[16'hC100 + i] = 8'(i) ^ 8'hA5;
        end
        mem[16'hC200] = 8'h77;

        reset = 1'b1;
        idle_bus();
        tick();
        tick();
        check_eq("rst_active", dma_active, 0);
        check_eq("rst_we", mem_we, 0);
        check_eq("rst_oe", mem_oe, 0);
        cpu_addr = 16'hFF46;
        cpu_re   = 1'b1;
        #1;
        check_eq("rst_src", cpu_rdata, 8'h00);
        check_eq("rst_re", mem_re, 0);
        reset = 1'b0;
        idle_bus();
        tick();

        // Full copy from page C0 with CPU traffic in the middle.
        start_dma(8'hC0);
        n = 0;
        while (dma_active && n < 1000) begin
            if (n == 0) begin
                check_eq("b0_rd_addr", mem_addr, 16'hC000);
                check_eq("b0_re", mem_re, 1);
                check_eq("b0_no_we", mem_we, 0);
            end
            if (n == 1) begin
                check_eq("b0_wr_addr", mem_addr, 16'hFE00);
                check_eq("b0_we", mem_we, 1);
                check_eq("b0_oe", mem_oe, 1);
                check_eq("b0_wdata", mem_wdata, 8'h5A);
            end
            if (n == 10) begin
                cpu_addr = 16'hC200; cpu_wdata = 8'h33; cpu_we = 1'b1;
                #1;
                check_eq("blk_wr_addr", mem_addr, 16'hC005);
            end
            if (n == 12) begin
                cpu_addr = 16'hC200; cpu_re = 1'b1;
                #1;
                check_eq("blk_rd", cpu_rdata, 8'hFF);
            end
            if (n == 14) begin
                cpu_addr = 16'hFF46; cpu_re = 1'b1;
                #1;
                check_eq("src_during", cpu_rdata, 8'hC0);
            end
            if (n == 319) begin
                check_eq("last_addr", mem_addr, 16'hFE9F);
                check_eq("last_wdata", mem_wdata, 8'hC5);
            end
            tick();
            idle_bus();
            n++;
        end
        check_eq("copy_len", n, 320);
        check_oam("oam_c0", 0, 159, 8'h5A);
        cpu_addr = 16'hC200; cpu_re = 1'b1;
        #1;
        check_eq("pass_resume_re", mem_re, 1);
        check_eq("dropped_wr", cpu_rdata, 8'h77);
        cpu_addr = 16'hFF46;
        #1;
        check_eq("src_after", cpu_rdata, 8'hC0);
        check_eq("src_idle_re", mem_re, 0);
        check_eq("src_idle_we", mem_we, 0);
        idle_bus();
        tick();

        // Restart with page C1 while byte 80 is being read.
        start_dma(8'hC0);
        n = 0;
        while (dma_active && n < 160) begin
            tick();
            n++;
        end
        check_eq("pre_restart", n, 160);
        start_dma(8'hC1);
        check_eq("restart_addr", mem_addr, 16'hC100);
        check_eq("restart_re", mem_re, 1);
        n = 0;
        while (dma_active && n < 1000) begin
            tick();
            n++;
        end
        check_eq("restart_len", n, 320);
        check_oam("oam_c1", 0, 159, 8'hA5);

        // Reset in the middle of byte 50.
        start_dma(8'hC0);
        n = 0;
        while (dma_active && n < 100) begin
            tick();
            n++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_rst_active", dma_active, 0);
        cpu_addr = 16'hFF46; cpu_re = 1'b1;
        #1;
        check_eq("mid_rst_src", cpu_rdata, 8'h00);
        idle_bus();
        we_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            if (mem_we) we_cnt++;
            tick();
        end
        check_eq("no_we_after_rst", we_cnt, 0);
        check_oam("oam_written", 0, 49, 8'h5A);
        check_oam("oam_kept", 50, 159, 8'hA5);

        // Reset beats a simultaneous register write.
        reset = 1'b1;
        cpu_addr = 16'hFF46; cpu_wdata = 8'hC3; cpu_we = 1'b1;
        tick();
        reset = 1'b0;
        idle_bus();
        check_eq("rst_wins", dma_active, 0);

        // Idle pass-through write then read.
        cpu_addr = 16'hD000; cpu_wdata = 8'hA5; cpu_we = 1'b1;
        #1;
        check_eq("pt_wr_addr", mem_addr, 16'hD000);
        check_eq("pt_we", mem_we, 1);
        check_eq("pt_oe", mem_oe, 1);
        tick();
        idle_bus();
        cpu_addr = 16'hD000; cpu_re = 1'b1;
        #1;
        check_eq("pt_rd_addr", mem_addr, 16'hD000);
        check_eq("pt_rdata", cpu_rdata, 8'hA5);
        check_eq("pt_oe_rd", mem_oe, 0);
        idle_bus();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
